// File: rtl/lmc_mem_pkg.sv
// Shared encodings for the LMC RAM master: command op codes and controller states.
package lmc_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_SUM   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SWEEP  = 2'b10,
        RESP   = 2'b11
    } state_e;

endpackage

// File: rtl/lmc_ram_master.sv
// Initiator for the LMC single-port RAM: turns valid/ready commands into RAM accesses
// and recirculates RAM_out into data_in whenever it is not deliberately writing.
module lmc_ram_master
    import lmc_mem_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_adr,
    input  logic [M-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [M-1:0] rsp_data,
    output logic         busy,
    output logic [N-1:0] ram_adr,
    output logic [M-1:0] ram_data_in,
    input  logic [M-1:0] ram_out
);

    state_e       state;
    op_e          op_q;
    logic [N-1:0] adr_q;
    logic [N-1:0] cnt;
    logic [M-1:0] data_q;
    logic [M-1:0] acc;
    logic [M-1:0] rsp_data_q;
    logic [M-1:0] sum_next;
    logic         wr_en;

    assign sum_next = acc + ram_out;

    // Writes are gated by rst_n so an aborted FILL/WRITE never corrupts RAM during reset.
    always_comb begin
        wr_en = rst_n && ((state == ACCESS && op_q == OP_WRITE) ||
                          (state == SWEEP  && op_q == OP_FILL));
        ram_adr     = (state == SWEEP) ? cnt : adr_q;
        ram_data_in = wr_en ? data_q : ram_out;
    end

    assign cmd_ready = rst_n && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_READ;
            adr_q      <= '0;
            data_q     <= '0;
            cnt        <= '0;
            acc        <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= op_e'(cmd_op);
                        adr_q  <= cmd_adr;
                        data_q <= cmd_data;
                        cnt    <= '0;
                        acc    <= '0;
                        state  <= cmd_op[1] ? SWEEP : ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_data_q <= (op_q == OP_WRITE) ? data_q : ram_out;
                    state      <= RESP;
                end
                SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (op_q == OP_SUM)
                        acc <= sum_next;
                    if (cnt == '1) begin
                        rsp_data_q <= (op_q == OP_FILL) ? data_q : sum_next;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmc_ram_master.sv
// Bench for lmc_ram_master: behavioural RAM plus an array-level reference of its contents.
module tb_lmc_ram_master;
    localparam int N = 2;
    localparam int M = 4;
    localparam int D = 1 << N;

    logic         clk = 0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_adr;
    logic [M-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [M-1:0] rsp_data;
    logic         busy;
    logic [N-1:0] ram_adr;
    logic [M-1:0] ram_data_in;
    logic [M-1:0] ram_out;

    int checks = 0;
    int errors = 0;

    // RAM under control: write every edge, combinational read
    logic [M-1:0] mem      [D];
    logic [M-1:0] load_val [D];
    logic         load;
    logic [M-1:0] ref_mem  [D];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) mem <= load_val;
        else      mem[ram_adr] <= ram_data_in;
    end
    assign ram_out = mem[ram_adr];

    lmc_ram_master #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_adr(cmd_adr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .ram_adr(ram_adr), .ram_data_in(ram_data_in), .ram_out(ram_out)
    );

    // Reference: apply the op to ref_mem and return the expected response.
    function automatic logic [M-1:0] model_op(input logic [1:0] op, input logic [N-1:0] a,
                                              input logic [M-1:0] d);
        int s = 0;
        case (op)
            2'b00: return ref_mem[a];
            2'b01: begin ref_mem[a] = d; return d; end
            2'b10: begin for (int i = 0; i < D; i++) ref_mem[i] = d; return d; end
            default: begin
                for (int i = 0; i < D; i++) s += int'(ref_mem[i]);
                return M'(s % (1 << M));
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return op[1] ? D : 1;
    endfunction

    // Issue one command and complete the response handshake. lat = -1 on timeout.
    task automatic do_cmd(input logic [1:0] op, input logic [N-1:0] a, input logic [M-1:0] d,
                          output logic [M-1:0] rd, output int lat);
        int k = 0;
        lat = -1;
        rd  = '0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_adr = a; cmd_data = d;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) begin cmd_valid = 0; return; end
        @(posedge clk); #1;
        cmd_valid = 0;
        cmd_adr = N'($urandom); cmd_data = M'($urandom);
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = i; break; end
        end
        if (lat < 0) return;
        rd = rsp_data;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; rsp_ready = 0; cmd_op = 0; cmd_adr = 0; cmd_data = 0;
        for (int i = 0; i < D; i++) begin
            load_val[i] = M'($urandom);
            ref_mem[i]  = load_val[i];
        end
        load = 1;
        @(posedge clk); #1;
        load = 0;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (ram_adr !== 2'd0) begin errors++; $display("FAIL reset_ram_adr: got %h expected 0", ram_adr); end
        @(negedge clk); rst_n = 1; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        logic [M-1:0] rd, exp;
        int lat;
        do_cmd(2'b01, 2'd2, 4'hA, rd, lat); exp = model_op(2'b01, 2'd2, 4'hA);
        checks++; if (rd !== exp || lat != 1) begin errors++; $display("FAIL write_rsp: got %h lat %0d expected %h lat 1", rd, lat, exp); end
        do_cmd(2'b00, 2'd2, 4'h0, rd, lat); exp = model_op(2'b00, 2'd2, 4'h0);
        checks++; if (rd !== 4'hA || lat != 1) begin errors++; $display("FAIL read_rsp: got %h lat %0d expected a lat 1", rd, lat); end
        for (int i = 0; i < D; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL wr_rd_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_fill_sum();
        logic [M-1:0] rd, exp;
        int lat;
        do_cmd(2'b10, 2'd1, 4'h3, rd, lat); exp = model_op(2'b10, 2'd1, 4'h3);
        checks++; if (rd !== exp || lat != D) begin errors++; $display("FAIL fill_rsp: got %h lat %0d expected %h lat %0d", rd, lat, exp, D); end
        for (int i = 0; i < D; i++) begin
            do_cmd(2'b00, N'(i), 4'h0, rd, lat);
            checks++; if (rd !== 4'h3 || lat != 1) begin errors++; $display("FAIL fill_read[%0d]: got %h lat %0d expected 3 lat 1", i, rd, lat); end
        end
        do_cmd(2'b11, 2'd0, 4'h0, rd, lat); exp = model_op(2'b11, 2'd0, 4'h0);
        checks++; if (rd !== 4'hC || lat != D) begin errors++; $display("FAIL fill_sum: got %h lat %0d expected c lat %0d", rd, lat, D); end
    endtask

    task automatic test_sum_wrap();
        logic [M-1:0] rd, exp;
        logic [M-1:0] vals [D];
        int lat;
        vals[0] = 4'hF; vals[1] = 4'h1; vals[2] = 4'h2; vals[3] = 4'h0;
        for (int i = 0; i < D; i++) begin
            do_cmd(2'b01, N'(i), vals[i], rd, lat); exp = model_op(2'b01, N'(i), vals[i]);
        end
        do_cmd(2'b11, 2'd3, 4'h9, rd, lat); exp = model_op(2'b11, 2'd3, 4'h9);
        checks++; if (rd !== 4'h2 || exp !== 4'h2 || lat != D) begin errors++; $display("FAIL sum_wrap: got %h lat %0d expected 2 lat %0d", rd, lat, D); end
    endtask

    task automatic test_stall();
        logic [M-1:0] exp;
        logic [N-1:0] a;
        int k = 0;
        a = N'($urandom);
        exp = model_op(2'b00, a, 4'h0);
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'b00; cmd_adr = a; cmd_data = 4'h0;
        @(posedge clk); #1;
        cmd_valid = 0;
        while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
        // Offer a WRITE while the response is held; it must be ignored.
        cmd_valid = 1; cmd_op = 2'b01; cmd_adr = a + 1'b1; cmd_data = ~ref_mem[a + 1'b1];
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: got valid %b data %h ready %b busy %b expected 1 %h 0 1",
                         i, rsp_valid, rsp_data, cmd_ready, busy, exp);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 0; rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy: got %b expected 0", busy); end
        for (int i = 0; i < D; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL stall_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [M-1:0] rd, exp;
        int lat;
        for (int i = 0; i < D; i++) begin
            do_cmd(2'b01, N'(i), M'(i + 1), rd, lat); exp = model_op(2'b01, N'(i), M'(i + 1));
        end
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'b10; cmd_adr = 2'd0; cmd_data = 4'h5;
        @(posedge clk); #1;   // accepted
        cmd_valid = 0;
        @(posedge clk); @(posedge clk); #1;  // two sweep writes done
        rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL midfill_in_reset: got valid %b ready %b expected 0 0", rsp_valid, cmd_ready); end
        rst_n = 1; #1;
        ref_mem[0] = 4'h5; ref_mem[1] = 4'h5;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL midfill_release: got busy %b ready %b expected 0 1", busy, cmd_ready); end
        for (int i = 0; i < D; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL midfill_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_idle_preserve();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmd_valid = 0; cmd_op = 2'($urandom); cmd_adr = N'($urandom); cmd_data = M'($urandom);
            rst_n = !(i >= 3 && i < 6);
            #1;
            checks++; if (ram_data_in !== ram_out) begin errors++; $display("FAIL idle_recirc%0d: got %h expected %h", i, ram_data_in, ram_out); end
        end
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < D; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL idle_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_random();
        logic [M-1:0] rd, exp, d;
        logic [N-1:0] a;
        logic [1:0]   op;
        int lat;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom); a = N'($urandom); d = M'($urandom);
            do_cmd(op, a, d, rd, lat); exp = model_op(op, a, d);
            checks++;
            if (rd !== exp || lat != exp_lat(op)) begin
                errors++;
                $display("FAIL rand%0d op%0d: got %h lat %0d expected %h lat %0d", n, op, rd, lat, exp, exp_lat(op));
            end
        end
        for (int i = 0; i < D; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill_sum();
        test_sum_wrap();
        test_stall();
        test_reset_mid_fill();
        test_idle_preserve();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmc_ram_master.md
Name: lmc_ram_master

Overview:
- Initiator-side controller for the LMC single-port RAM. That RAM writes `mem[adr] <= data_in` on every clk edge and reads `RAM_out = mem[adr]` combinationally.
- This block owns the RAM's `adr`/`data_in` pins and turns valid/ready commands into safe accesses. Supported commands: READ, WRITE, FILL (all words) and SUM (checksum of all words).
- Whenever it is not deliberately writing, it drives the RAM's own output back into `data_in`, so contents are preserved.
- Sits between the LMC control unit / loader and the RAM.

Parameters:
- N, 2, RAM address width; depth 2**N.
- M, 4, RAM data width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready at a rising edge
- cmd_op  in  2  00 READ, 01 WRITE, 10 FILL, 11 SUM
- cmd_adr  in  N  address for READ/WRITE; ignored for FILL/SUM
- cmd_data  in  M  write/fill value; ignored for READ/SUM
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&&ready at a rising edge
- rsp_data  out  M  READ: word; WRITE/FILL: value written; SUM: checksum
- busy  out  1  high in any state other than IDLE
- ram_adr  out  N  to RAM adr
- ram_data_in  out  M  to RAM data_in
- ram_out  in  M  from RAM RAM_out

Behaviour:
- Reset: synchronous, active-low, only at a rising edge with rst_n=0.
  - Result: state=IDLE, rsp_valid=0, rsp_data=0, adr_q=0, data_q=0, sweep counter=0, acc=0.
  - cmd_ready=0 while rst_n=0.
- Contents preservation: ram_data_in=ram_out in every cycle except write cycles (ACCESS with op WRITE, SWEEP with op FILL). This holds during reset too, so RAM contents survive reset.
- States: IDLE, ACCESS, SWEEP, RESP.
- IDLE:
  - cmd_ready=1 (when rst_n=1).
  - ram_adr=adr_q.
  - On accept: latch op/adr/data into op_q/adr_q/data_q.
  - READ/WRITE go to ACCESS. FILL/SUM go to SWEEP with counter=0 and acc=0.
- ACCESS (exactly 1 cycle):
  - ram_adr=adr_q.
  - WRITE: ram_data_in=data_q, so the RAM writes at the closing edge; rsp_data<=data_q.
  - READ: rsp_data<=ram_out.
  - Next state RESP.
- SWEEP (exactly 2**N cycles):
  - ram_adr=counter.
  - FILL: ram_data_in=data_q.
  - SUM: acc<=acc+ram_out, mod 2**M (carry discarded).
  - Counter increments each cycle.
  - When counter==2**N-1: rsp_data<=data_q (FILL) or acc+ram_out (SUM); go to RESP; counter wraps to 0.
- RESP:
  - rsp_valid=1; rsp_data is stable.
  - ram_adr=adr_q; no write.
  - Leave to IDLE on the edge where rsp_ready=1.
- Latency, counted from the accepting edge E0:
  - READ/WRITE: rsp_valid high after E1. The WRITE takes effect at E1.
  - FILL/SUM: rsp_valid high after edge E(2**N).
  - Next command is accepted no earlier than the edge after the response handshake. READ/WRITE throughput is therefore at best 1 op per 3 cycles.
- cmd_ready=0 in ACCESS, SWEEP and RESP. cmd_valid there is ignored, not queued.
- rsp_ready outside RESP is ignored.
- Reset mid-operation:
  - The operation aborts and no response is produced.
  - FILL: addresses already swept keep the fill value; the rest keep their old contents.
- All four op codes are defined; there is no error response.

Decomposition:
- Package lmc_mem_pkg: op codes OP_READ/OP_WRITE/OP_FILL/OP_SUM (2-bit) and the state enum IDLE/ACCESS/SWEEP/RESP.
- Sub-modules: none in RTL; the counter and accumulator are inline.
- The bench instantiates the existing LMC RAM with matching N/M and connects ram_adr/ram_data_in/ram_out.

Test Plan:
1. Reset, then WRITE adr=2 data=0xA, then READ adr=2 -> READ rsp_data=0xA with rsp_valid after E1 of its accept; addresses 0, 1 and 3 unchanged from their pre-test values.
2. FILL data=0x3 -> rsp_valid after E4, rsp_data=0x3; READs of addresses 0..3 all return 0x3; a following SUM returns 0xC.
3. WRITE 0:0xF, 1:0x1, 2:0x2, 3:0x0, then SUM -> rsp_data=0x2 (18 mod 16), response after E4.
4. READ with rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable throughout, cmd_ready=0, busy=1; a concurrent cmd_valid WRITE does not modify the RAM.
5. FILL 0x5 over contents 0x1,0x2,0x3,0x4; pull rst_n low after 2 sweep cycles -> RAM holds 5,5,3,4; rsp_valid=0; busy=0 and cmd_ready=1 after reset is released.
6. Idle for 10 cycles with random cmd_adr/cmd_data and cmd_valid=0, including 3 cycles with rst_n=0 -> RAM contents are unchanged and ram_data_in==ram_out in every cycle.
